// File: rtl/hazard_tracker_pkg.sv
// Shared pipeline types for the hazard tracker:
// register width, x0 constant, slot bundle and slot/source match.
package hazard_tracker_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } slot_t;

  function automatic logic slot_match(
    input slot_t            s,
    input logic [REG_W-1:0] rs,
    input logic             used
  );
    return s.valid && s.regwrite && used &&
           (s.rd != REG_ZERO) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_tracker_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
// Cleared asynchronously by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks EX/MEM/WB destinations and raises the ID stall for
// load-use and branch-in-ID hazards; counts stall cycles.
import hazard_tracker_pkg::*;

module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic [REG_W-1:0] issue_rd_i,
  input  logic             issue_regwrite_i,
  input  logic             issue_memread_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             stall_o,
  output logic [REG_W-1:0] ex_rd_o,
  output logic [REG_W-1:0] mem_rd_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  slot_t ex_q, mem_q, wb_q, id_slot;
  logic  ex_hit, mem_hit, stall;
  logic  unused_wb;

  always_comb begin
    ex_hit  = slot_match(ex_q, rs1_i, rs1_used_i) ||
              slot_match(ex_q, rs2_i, rs2_used_i);
    mem_hit = slot_match(mem_q, rs1_i, rs1_used_i) ||
              slot_match(mem_q, rs2_i, rs2_used_i);
    stall   = issue_valid_i && !flush_i &&
              ((ex_hit && ex_q.memread) ||
               (branch_i && ex_hit) ||
               (branch_i && mem_hit && mem_q.memread));
    id_slot = '0;
    if (issue_valid_i && !stall && !flush_i) begin
      id_slot.valid    = 1'b1;
      id_slot.rd       = issue_rd_i;
      id_slot.regwrite = issue_regwrite_i;
      id_slot.memread  = issue_memread_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!mem_stall_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= id_slot;
    end
  end

  // WB never stalls; its type bits are tracked only for visibility.
  assign unused_wb = ^{wb_q.regwrite, wb_q.memread};

  assign stall_o  = stall;
  assign ex_rd_o  = ex_q.valid  ? ex_q.rd  : REG_ZERO;
  assign mem_rd_o = mem_q.valid ? mem_q.rd : REG_ZERO;
  assign wb_rd_o  = wb_q.valid  ? wb_q.rd  : REG_ZERO;

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall && !mem_stall_i),
    .cnt_o (stall_cnt_o)
  );

endmodule
